ram_port_arbiter: RTL

Two-client controller that shares one `dual_address_ram` (16 x 8, one write path, two read ports) between client A and client B. Each client issues read or write requests over a req/gnt handshake. The arbiter drives all RAM control pins, grants concurrent reads on the two ports, and serialises writes with round-robin fairness. Read data returns to each client with a registered valid strobe. It sits directly in front of the RAM and is the only agent driving it.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_rd_delay.sv | 33 +++
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-client RAM port arbiter.
// Address/data widths here are defaults only; modules take them as parameters.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        CLI_A = 1'b0,
        CLI_B = 1'b1
    } client_t;

    // Level driven onto the RAM enable pins when nothing is granted.
    localparam logic RAM_EN_IDLE = 1'b0;
    localparam logic RAM_WR_IDLE = 1'b0;

endpackage

// File: rtl/ram_rd_delay.sv
// RD_LAT-deep valid shift register that tracks a read grant until the RAM
// output for it is valid; synchronous clear drops everything in flight.
module ram_rd_delay #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic vld_in,
    output logic vld_out
);

    logic [RD_LAT-1:0] sr_q;
    logic [RD_LAT-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = vld_in;
        for (int i = 1; i < RD_LAT; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign vld_out = sr_q[RD_LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 16x8 dual-read RAM between clients A and B: concurrent reads on
// separate ports, writes serialised through port 0 with round-robin fairness.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [ADDR_W-1:0] ram_addr_0,
    output logic [ADDR_W-1:0] ram_addr_1,
    output logic              ram_port_en_0,
    output logic              ram_port_en_1,
    input  logic [DATA_W-1:0] ram_data_out_0,
    input  logic [DATA_W-1:0] ram_data_out_1
);

    client_t           prio_q, prio_d;
    logic              contested;
    logic              rd_issue_a, rd_issue_b;
    logic              tap_a, tap_b;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    // Grants are suppressed during reset so no write can land on that edge.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        contested = 1'b0;
        if (!rst) begin
            if (req_a && req_b) begin
                if (!we_a && !we_b) begin
                    gnt_a = 1'b1;
                    gnt_b = 1'b1;
                end else begin
                    contested = 1'b1;
                    gnt_a     = (prio_q == CLI_A);
                    gnt_b     = (prio_q == CLI_B);
                end
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (contested) begin
            prio_d = gnt_a ? CLI_B : CLI_A;
        end
    end

    always_comb begin
        ram_wr_en     = RAM_WR_IDLE;
        ram_port_en_0 = RAM_EN_IDLE;
        ram_port_en_1 = RAM_EN_IDLE;
        ram_addr_0    = '0;
        ram_addr_1    = '0;
        ram_data_in   = '0;
        if (gnt_a && we_a) begin
            ram_wr_en     = 1'b1;
            ram_port_en_0 = 1'b1;
            ram_addr_0    = addr_a;
            ram_data_in   = wdata_a;
        end else if (gnt_b && we_b) begin
            ram_wr_en     = 1'b1;
            ram_port_en_0 = 1'b1;
            ram_addr_0    = addr_b;
            ram_data_in   = wdata_b;
        end else begin
            if (gnt_a) begin
                ram_port_en_0 = 1'b1;
                ram_addr_0    = addr_a;
            end
            if (gnt_b) begin
                ram_port_en_1 = 1'b1;
                ram_addr_1    = addr_b;
            end
        end
    end

    assign rd_issue_a = gnt_a && !we_a;
    assign rd_issue_b = gnt_b && !we_b;

    ram_rd_delay #(.RD_LAT(RD_LAT)) u_dly_a (
        .clk     (clk),
        .clr     (rst),
        .vld_in  (rd_issue_a),
        .vld_out (tap_a)
    );

    ram_rd_delay #(.RD_LAT(RD_LAT)) u_dly_b (
        .clk     (clk),
        .clr     (rst),
        .vld_in  (rd_issue_b),
        .vld_out (tap_b)
    );

    // RAM output is only trusted on the tap cycle; hold the last value otherwise.
    always_comb begin
        rvalid_a_d = tap_a;
        rvalid_b_d = tap_b;
        rdata_a_d  = tap_a ? ram_data_out_0 : rdata_a_q;
        rdata_b_d  = tap_b ? ram_data_out_1 : rdata_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= CLI_A;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            prio_q     <= prio_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;

endmodule
